// File: rtl/playback_sequencer.sv
// playback_sequencer: steps through a colour pattern, showing each colour then a dark gap, each timed by a shared external step timer.
module playback_sequencer #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic              start_timer,
  input  logic              timer_done,
  output logic [3:0]        led,
  output logic [ADDR_W:0]   step,
  output logic              busy,
  output logic              done
);
  localparam int MAX_LEN = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] MAX = (ADDR_W + 1)'(MAX_LEN);
  typedef enum logic [2:0] {IDLE, SHOW_ARM, SHOW_WAIT, GAP_ARM, GAP_WAIT} state_t;
  state_t            state_q;
  logic [ADDR_W:0]   idx_q, len_q;
  logic [1:0]        colour_q;
  logic              first_q, start_timer_q, busy_q, done_q;
  logic [3:0]        led_q;
  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction
  assign rd_addr     = idx_q[ADDR_W-1:0];
  assign step        = idx_q;
  assign start_timer = start_timer_q;
  assign led         = led_q;
  assign busy        = busy_q;
  assign done        = done_q;
  // Outputs are registered alongside the state, so each is computed for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      len_q         <= '0;
      colour_q      <= '0;
      first_q       <= 1'b0;
      start_timer_q <= 1'b0;
      led_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      start_timer_q <= 1'b0;
      done_q        <= 1'b0;
      led_q         <= '0;
      busy_q        <= 1'b1;
      if (abort && state_q != IDLE) begin
        state_q <= IDLE;
        idx_q   <= '0;
        first_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            idx_q  <= '0;
            busy_q <= start && length != '0;
            done_q <= start && length == '0;
            if (start && length != '0) begin
              len_q         <= length > MAX ? MAX : length;
              colour_q      <= rd_data;
              led_q         <= onehot(rd_data);
              start_timer_q <= 1'b1;
              state_q       <= SHOW_ARM;
            end
          end
          SHOW_ARM: begin
            led_q   <= onehot(colour_q);
            first_q <= 1'b1;
            state_q <= SHOW_WAIT;
          end
          SHOW_WAIT: begin
            first_q <= 1'b0;
            led_q   <= (!first_q && timer_done) ? 4'b0000 : onehot(colour_q);
            if (!first_q && timer_done) begin
              idx_q         <= idx_q + 1'b1;
              start_timer_q <= 1'b1;
              state_q       <= GAP_ARM;
            end
          end
          GAP_ARM: begin
            first_q <= 1'b1;
            state_q <= GAP_WAIT;
          end
          GAP_WAIT: begin
            first_q <= 1'b0;
            if (!first_q && timer_done && idx_q == len_q) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else if (!first_q && timer_done) begin
              colour_q      <= rd_data;
              led_q         <= onehot(rd_data);
              start_timer_q <= 1'b1;
              state_q       <= SHOW_ARM;
            end
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_playback_sequencer.sv
// tb_playback_sequencer: scoreboard bench; expected timer-pulse and done events come from a pattern-level model.
module tb_playback_sequencer;
  logic clk = 0, reset = 1, start = 0, abort = 0, timer_done;
  logic [4:0] length = 0, step;
  logic [3:0] rd_addr, led;
  logic [1:0] rd_data;
  logic start_timer, busy, done;
  logic [1:0] pat [16];
  int lat = 3, cnt = 0;
  int checks = 0, fails = 0;
  typedef struct {bit is_done; logic [3:0] led; logic [4:0] step;} ev_t;
  ev_t exp_q[$];

  playback_sequencer #(.ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .length(length),
    .rd_addr(rd_addr), .rd_data(rd_data), .start_timer(start_timer),
    .timer_done(timer_done), .led(led), .step(step), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign rd_data = pat[rd_addr];
  assign timer_done = cnt == 0;
  always @(posedge clk or posedge reset)
    if (reset) cnt <= 0;
    else if (start_timer) cnt <= lat;
    else if (cnt != 0) cnt <= cnt - 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (start_timer || done)) begin
      if (exp_q.size() == 0) chk("unexpected_event", {30'd0, done, start_timer}, 0);
      else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event_kind", int'(done), int'(e.is_done));
        chk("event_led", int'(led), int'(e.led));
        chk("event_step", int'(step), int'(e.step));
        if (e.is_done) chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic model(input int len);
    int n;
    n = len > 16 ? 16 : len;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{1'b0, 4'(1 << pat[i]), 5'(i)});
      exp_q.push_back('{1'b0, 4'd0, 5'(i + 1)});
    end
    exp_q.push_back('{1'b1, 4'd0, 5'(n)});
  endtask

  task automatic issue(input int len);
    model(len);
    @(posedge clk); #1 start = 1; length = 5'(len);
    @(posedge clk); #1 start = 0;
    if (len == 0) chk("busy_len0", int'(busy), 0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
    chk({name, "_timeout"}, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1 chk({name, "_busy_after"}, int'(busy), 0);
    chk({name, "_led_after"}, int'(led), 0);
    chk({name, "_step_after"}, int'(step), 0);
  endtask

  task automatic wait_for(input string name, input bit show, input int s);
    int n = 0;
    @(negedge clk);
    while (!(busy && !start_timer && step == 5'(s) && ((led != 0) == show)) && n < 500) begin
      @(negedge clk); n++;
    end
    chk({name, "_reached"}, int'(n < 500), 1);
  endtask

  initial begin
    pat[0] = 2; pat[1] = 0; pat[2] = 3; pat[3] = 1;
    for (int i = 4; i < 16; i++) pat[i] = 2'($urandom_range(3));
    #1 chk("rst_led", int'(led), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_start_timer", int'(start_timer), 0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    issue(3); drain("len3");
    issue(0); drain("len0");
    issue(20); drain("len20");
    issue(4);
    wait_for("abort", 1, 1);
    abort = 1; exp_q.delete();
    @(posedge clk); #1 abort = 0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_led", int'(led), 0);
    chk("abort_start_timer", int'(start_timer), 0);
    repeat (20) @(posedge clk);
    issue(2); drain("after_abort");
    issue(3);
    repeat (5) @(posedge clk);
    #1 start = 1; length = 9;
    @(posedge clk); #1 start = 0;
    drain("restart_ignored");
    issue(3);
    wait_for("reset", 0, 1);
    reset = 1; exp_q.delete();
    #1 chk("async_led", int'(led), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_start_timer", int'(start_timer), 0);
    chk("async_step", int'(step), 0);
    chk("async_done", int'(done), 0);
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk) chk("post_reset_busy", int'(busy), 0);
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 16; i++) pat[i] = 2'($urandom_range(3));
      lat = $urandom_range(4);
      issue($urandom_range(31));
      drain("random");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/playback_sequencer.md
PLAYBACK_SEQUENCER -- requirements
Module: playback_sequencer

Interface
REQ-001 SHALL have parameter: ADDR_W, 4, pattern address width; maximum sequence length MAX_LEN = 2**ADDR_W.
REQ-002 SHALL have ports, one per line:
  clk  input  1  clock, all state on rising edge
  reset  input  1  asynchronous, active-high
  start  input  1  request playback; sampled only in IDLE
  abort  input  1  cancel playback; highest priority after reset
  length  input  ADDR_W+1  number of steps to play, sampled with start
  rd_addr  output  ADDR_W  pattern memory read address
  rd_data  input  2  colour code at rd_addr, combinational, same cycle
  start_timer  output  1  one-cycle pulse that loads the shared step timer
  timer_done  input  1  high while the step timer is expired
  led  output  4  one-hot colour display, led[rd_data code]; 0 = dark
  step  output  ADDR_W+1  steps completed so far
  busy  output  1  high whenever the state is not IDLE
  done  output  1  one-cycle pulse on normal completion
REQ-003 SHALL use reset as asynchronous, active-high; clock clk.

Function
REQ-004 SHALL implement states IDLE, SHOW_ARM, SHOW_WAIT, GAP_ARM, GAP_WAIT.
REQ-005 SHALL hold idx = 0 in IDLE; rd_addr = idx[ADDR_W-1:0] in all states; step = idx.
REQ-006 SHALL, in IDLE with start=1 and length>0, latch len_q = min(length, MAX_LEN), latch colour_q <= rd_data (address 0), and go to SHOW_ARM.
REQ-007 SHALL, in IDLE with start=1 and length=0, stay IDLE, not pulse start_timer, and pulse done in the next cycle.
REQ-008 SHALL drive start_timer = 1 exactly in SHOW_ARM and GAP_ARM; each ARM state lasts one cycle, then goes to its WAIT state.
REQ-009 SHALL ignore timer_done in the first cycle of each WAIT state; after that, it SHALL exit at the first edge with timer_done=1.
REQ-010 SHALL drive led = one-hot(colour_q) in SHOW_ARM and SHOW_WAIT, and led = 0 in all other states.
REQ-011 SHALL, on SHOW_WAIT exit, increment idx and go to GAP_ARM.
REQ-012 SHALL, on GAP_WAIT exit, go to IDLE with done=1 for the following cycle if idx == len_q; otherwise it SHALL latch colour_q <= rd_data (address idx) and go to SHOW_ARM.
REQ-013 SHALL generate done from a register, high for exactly one cycle, coincident with the first IDLE cycle after completion.
REQ-014 SHALL ignore start while busy, and SHALL NOT change length mid-playback, since len_q is latched.
REQ-015 SHALL, on abort=1 in any non-IDLE state, go to IDLE at the next edge with led=0 and start_timer=0, and SHALL NOT pulse done; abort in IDLE SHALL be ignored, and abort outranks start in the same cycle.
REQ-016 SHALL, when len_q = MAX_LEN, let idx reach MAX_LEN without wrap, so the ADDR_W+1 width is required.
REQ-017 SHALL produce a single step as SHOW (ARM + wait) followed by GAP (ARM + wait); a gap also follows the final step.

Reset
REQ-018 SHALL, while reset=1, force state=IDLE, idx=0, len_q=0, colour_q=0, led=0, start_timer=0, busy=0, done=0, step=0.
REQ-019 SHALL, on reset asserted mid-playback, clear led and busy immediately (asynchronously) and produce no done pulse.

Verification
REQ-020 SHALL pass these directed scenarios, using a bench timer model that is done after 3 cycles, and pattern {2,0,3,1}:
  - length=3, start pulse -> led 0100, 0000, 0001, 0000, 1000, 0000; start_timer 6 pulses; done one cycle; step ends at 3; busy low after.
  - length=0, start -> no start_timer pulse, led stays 0, done=1 exactly one cycle later, busy never high.
  - length=20 (ADDR_W=4) -> clamped to 16 steps, 32 start_timer pulses, step=16 at completion, rd_addr never exceeds 15.
  - abort asserted during second SHOW_WAIT -> IDLE next edge, led=0, done never pulses, new start then works from step 0.
  - start re-pulsed while busy and length changed -> ignored; playback length unchanged.
  - reset asserted mid GAP_WAIT -> all outputs 0 immediately; after release, IDLE with busy=0.
